// File: rtl/fnd_scan_pkg.sv
// Shared types and constants for the FND scan decoder: digit slot record, FSM states, segment codes.
// No logic here; helpers are pure combinational functions.
// No flow control.
package fnd_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = 14;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Active-low g..a patterns as they appear on the bus
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef struct packed {
        logic       inv;
        logic [3:0] bcd;
    } digit_t;

    function automatic logic com_legal(input logic [3:0] com);
        return (com == 4'b1110) || (com == 4'b1101) ||
               (com == 4'b1011) || (com == 4'b0111);
    endfunction

    // Only meaningful when com_legal() holds
    function automatic logic [1:0] com_slot(input logic [3:0] com);
        logic [1:0] idx;
        case (com)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/fnd_seg_to_bcd.sv
// Seven-segment (active-low g..a) pattern to BCD digit with an invalid flag.
// Purely combinational, zero latency.
// No flow control.
module fnd_seg_to_bcd
    import fnd_scan_pkg::*;
(
    input  logic [6:0] seg,
    output digit_t     digit
);

    always_comb begin
        digit.inv = 1'b0;
        digit.bcd = 4'd0;
        case (seg)
            SEG_0:   digit.bcd = 4'd0;
            SEG_1:   digit.bcd = 4'd1;
            SEG_2:   digit.bcd = 4'd2;
            SEG_3:   digit.bcd = 4'd3;
            SEG_4:   digit.bcd = 4'd4;
            SEG_5:   digit.bcd = 4'd5;
            SEG_6:   digit.bcd = 4'd6;
            SEG_7:   digit.bcd = 4'd7;
            SEG_8:   digit.bcd = 4'd8;
            SEG_9:   digit.bcd = 4'd9;
            default: digit.inv = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Decodes a sampled 4-digit multiplexed FND bus back to a 14-bit value; optional partial-frame timeout under FND_SCAN_TIMEOUT_EN.
// Latency: data/data_valid two cycles after the 4th digit capture.
// No backpressure: outputs are single-cycle pulses, the bus is sampled every cycle.
module fnd_scan_decoder
    import fnd_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fnd_com,
    input  logic [7:0]        fnd_data,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              seg_error,
    output logic              frame_busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

    generate
        if (SETTLE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("fnd_scan_decoder: SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic [3:0]            com_q;
    logic [7:0]            seg_q;
    logic [CNT_W-1:0]      stab_cnt;
    logic                  dwell_done;
    logic [NUM_DIGITS-1:0] captured;
    digit_t                slot [NUM_DIGITS];
    state_t                state;

    digit_t                dec;
    logic                  changed;
    logic                  capture;
    logic [1:0]            cap_idx;
    logic                  any_inv;
    logic [DATA_W-1:0]     frame_value;

`ifdef FND_SCAN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    fnd_seg_to_bcd u_seg_to_bcd (
        .seg   (seg_q[6:0]),
        .digit (dec)
    );

    assign changed    = {fnd_com, fnd_data} != {com_q, seg_q};
    assign capture    = (stab_cnt == SETTLE_MAX) && com_legal(com_q) && !dwell_done && (state == COLLECT);
    assign cap_idx    = com_slot(com_q);
    assign frame_busy = |captured;

    always_comb begin
        any_inv = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            any_inv = any_inv | slot[i].inv;
        end
    end

    // Slots hold 0..9 when no invalid flag is set, so the sum tops out at 9999
    assign frame_value = DATA_W'(slot[3].bcd) * DATA_W'(1000)
                       + DATA_W'(slot[2].bcd) * DATA_W'(100)
                       + DATA_W'(slot[1].bcd) * DATA_W'(10)
                       + DATA_W'(slot[0].bcd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_q      <= 4'hF;
            seg_q      <= 8'hFF;
            stab_cnt   <= '0;
            dwell_done <= 1'b0;
            captured   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot[i] <= '0;
            end
            state      <= COLLECT;
            data       <= '0;
            data_valid <= 1'b0;
            seg_error  <= 1'b0;
`ifdef FND_SCAN_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            com_q      <= fnd_com;
            seg_q      <= fnd_data;
            data_valid <= 1'b0;
            seg_error  <= 1'b0;

            if (changed) begin
                stab_cnt <= '0;
            end else if (stab_cnt != SETTLE_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            case (state)
                COLLECT: begin
                    if (&captured) begin
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (any_inv) begin
                        seg_error <= 1'b1;
                    end else begin
                        data       <= frame_value;
                        data_valid <= 1'b1;
                    end
                    state <= EMIT;
                end
                EMIT: begin
                    captured <= '0;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        slot[i].inv <= 1'b0;
                    end
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase

`ifdef FND_SCAN_TIMEOUT_EN
            // A complete frame already heading into CONVERT is never discarded
            if (data_valid || seg_error) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt <= '0;
                if (frame_busy && (state == COLLECT) && !(&captured)) begin
                    captured  <= '0;
                    seg_error <= 1'b1;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        slot[i].inv <= 1'b0;
                    end
                end
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif

            if (capture) begin
                slot[cap_idx]     <= dec;
                captured[cap_idx] <= 1'b1;
            end

            // A new dwell re-arms capture even if the old one captured on this edge
            if (changed) begin
                dwell_done <= 1'b0;
            end else if (capture) begin
                dwell_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: frame table, hand-written corner sequences, randomized dwells vs a frame-level model.
// Define FND_SCAN_TIMEOUT_EN to exercise the partial-frame timeout.
module tb_fnd_scan_decoder;

    localparam int SETTLE = 16;
    localparam int TMO    = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  fnd_com = 4'hF;
    logic [7:0]  fnd_data = 8'hFF;
    logic [13:0] data;
    logic        data_valid;
    logic        seg_error;
    logic        frame_busy;

    fnd_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fnd_com    (fnd_com),
        .fnd_data   (fnd_data),
        .data       (data),
        .data_valid (data_valid),
        .seg_error  (seg_error),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dv_cnt = 0;
    int se_cnt = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit err;
        int val;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    logic [6:0] seg7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int m_dig [4];
    bit m_inv [4];
    bit [3:0] m_cap;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                dv_cnt++;
                if (chk_en) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", int'(data_valid), 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("model_valid_kind", int'(mon_e.err), 0);
                        check("model_data", int'(data), mon_e.val);
                    end
                end
            end
            if (seg_error) begin
                se_cnt++;
                if (chk_en) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_seg_error", int'(seg_error), 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("model_error_kind", int'(mon_e.err), 1);
                    end
                end
            end
        end
    end

    // Frame-level model: a legal dwell held at least SETTLE+1 cycles yields one digit
    task automatic model_dwell(input logic [3:0] c, input logic [7:0] s, input int len);
        int idx;
        int d;
        ev_t e;
        if (!chk_en) return;
        if ($countones(~c) != 1 || len < SETTLE + 1) return;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!c[i]) idx = i;
        d = -1;
        for (int k = 0; k < 10; k++) if (seg7[k] == s[6:0]) d = k;
        m_cap[idx] = 1'b1;
        m_inv[idx] = (d < 0);
        m_dig[idx] = (d < 0) ? 0 : d;
        if (&m_cap) begin
            e.err = m_inv[0] | m_inv[1] | m_inv[2] | m_inv[3];
            e.val = e.err ? 0 : m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
            exp_q.push_back(e);
            m_cap = '0;
            for (int i = 0; i < 4; i++) m_inv[i] = 1'b0;
        end
    endtask

    task automatic dwell(input logic [3:0] c, input logic [7:0] s, input int len);
        fnd_com  = c;
        fnd_data = s;
        model_dwell(c, s, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [31:0] segs);
        dwell(4'b1110, segs[7:0],   20);
        dwell(4'b1101, segs[15:8],  20);
        dwell(4'b1011, segs[23:16], 20);
        dwell(4'b0111, segs[31:24], 20);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] segs;      // thousands..ones
        bit          exp_err;
        int          exp_data;
    } vec_t;

    initial begin
        vec_t vt [6];
        int dv0, se0, d0, lat, seen;
        logic [3:0] c;
        logic [7:0] s;
        int len;

        vt[0] = '{32'hF9A4B099, 1'b0, 1234};
        vt[1] = '{32'h90909090, 1'b0, 9999};
        vt[2] = '{32'hC0C0C0F8, 1'b0, 7};
        vt[3] = '{32'hF9A4B0FF, 1'b1, 0};
        vt[4] = '{32'h40792430, 1'b0, 123};
        vt[5] = '{32'h82F88092, 1'b0, 6785};
        m_cap = '0;

        // Reset state
        @(negedge clk);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_seg_error", int'(seg_error), 0);
        check("rst_busy", int'(frame_busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Test 1 with latency: 4th capture on edge SETTLE+2 of its dwell, outputs two edges
        // later, first seen on the negedge numbered SETTLE+5 counted from the dwell start
        dv0 = dv_cnt; se0 = se_cnt;
        dwell(4'b1110, 8'h99, 20);
        dwell(4'b1101, 8'hB0, 20);
        dwell(4'b1011, 8'hA4, 20);
        check("t1_busy_partial", int'(frame_busy), 1);
        fnd_com = 4'b0111; fnd_data = 8'hF9;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (data_valid && lat < 0) lat = k;
        end
        @(posedge clk);
        #1;
        check("t1_latency", lat, SETTLE + 5);
        check("t1_data", int'(data), 1234);
        check("t1_valid_count", dv_cnt - dv0, 1);
        check("t1_seg_error_count", se_cnt - se0, 0);
        check("t1_busy_after", int'(frame_busy), 0);

        // Table of whole frames, ones digit first
        for (int i = 0; i < 6; i++) begin
            dv0 = dv_cnt; se0 = se_cnt; d0 = int'(data);
            frame(vt[i].segs);
            dwell(4'hF, 8'hFF, 5);
            check("tbl_valid_count", dv_cnt - dv0, vt[i].exp_err ? 0 : 1);
            check("tbl_err_count", se_cnt - se0, vt[i].exp_err ? 1 : 0);
            check("tbl_data", int'(data), vt[i].exp_err ? d0 : vt[i].exp_data);
            check("tbl_busy", int'(frame_busy), 0);
        end

        // Test 2: a short hundreds dwell is ignored until a full one arrives
        dv0 = dv_cnt;
        dwell(4'b1110, 8'h99, 20);
        dwell(4'b1101, 8'hB0, 20);
        dwell(4'b1011, 8'hA4, 10);
        dwell(4'b0111, 8'hF9, 20);
        check("t2_no_valid_yet", dv_cnt - dv0, 0);
        check("t2_busy", int'(frame_busy), 1);
        dwell(4'b1011, 8'hA4, 20);
        dwell(4'hF, 8'hFF, 5);
        check("t2_valid_count", dv_cnt - dv0, 1);
        check("t2_data", int'(data), 1234);

        // Test 4: reverse order 9999, then illegal commons never capture
        dv0 = dv_cnt; se0 = se_cnt;
        dwell(4'b0111, 8'h90, 20);
        dwell(4'b1011, 8'h90, 20);
        dwell(4'b1101, 8'h90, 20);
        dwell(4'b1110, 8'h90, 20);
        dwell(4'hF, 8'h90, 50);
        check("t4_data", int'(data), 9999);
        check("t4_busy_idle", int'(frame_busy), 0);
        dwell(4'b1100, 8'h90, 50);
        check("t4_busy_multi", int'(frame_busy), 0);
        check("t4_valid_count", dv_cnt - dv0, 1);
        check("t4_err_count", se_cnt - se0, 0);

        // Test 5: reset mid-frame
        dwell(4'b1110, 8'hC0, 20);
        dwell(4'b1101, 8'hC0, 20);
        check("t5_busy_before", int'(frame_busy), 1);
        reset = 1'b1;
        #1;
        check("t5_rst_data", int'(data), 0);
        check("t5_rst_busy", int'(frame_busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dv0 = dv_cnt;
        frame(32'hC0C0C0F8);
        dwell(4'hF, 8'hFF, 5);
        check("t5_data", int'(data), 7);
        check("t5_valid_count", dv_cnt - dv0, 1);

`ifdef FND_SCAN_TIMEOUT_EN
        // Test 6: lone digit is discarded after the timeout
        do_reset();
        se0 = se_cnt;
        dwell(4'b1110, 8'hC0, 20);
        check("t6_busy", int'(frame_busy), 1);
        fnd_com = 4'hF; fnd_data = 8'hFF;
        seen = 0;
        for (int k = 1; k <= 2 * TMO && seen == 0; k++) begin
            @(negedge clk);
            if (seg_error) seen = k;
        end
        check("t6_timeout_seen", int'(seen > 0), 1);
        check("t6_busy_after", int'(frame_busy), 0);
        check("t6_err_count", se_cnt - se0, 1);
        @(posedge clk);
        #1;
`else
        // Randomized dwells against the frame model
        do_reset();
        m_cap = '0;
        for (int i = 0; i < 4; i++) m_inv[i] = 1'b0;
        chk_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            c = 4'hF;
            if ($urandom_range(0, 19) < 17) begin
                c[$urandom_range(0, 3)] = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0: c = 4'hF;
                    1: c = 4'hC;
                    2: c = 4'h0;
                    default: c = 4'h5;
                endcase
            end
            if ($urandom_range(0, 9) < 8) s = {1'($urandom_range(0, 1)), seg7[$urandom_range(0, 9)]};
            else s = 8'($urandom);
            if ({c, s} == {fnd_com, fnd_data}) s = s ^ 8'h80;
            case ($urandom_range(0, 9))
                0: len = SETTLE;
                1: len = SETTLE + 1;
                2, 3: len = $urandom_range(3, SETTLE - 1);
                default: len = $urandom_range(SETTLE + 2, 30);
            endcase
            dwell(c, s, len);
        end
        dwell(4'hF, (fnd_com == 4'hF && fnd_data == 8'hFF) ? 8'hFE : 8'hFF, 10);
        chk_en = 1'b0;
        check("rand_queue_empty", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
